// File: rtl/regfile_dbg_port.sv
// Debug access initiator for the register file while the core is halted.
// DUMP streams R0..R(NREGS-1) out over a valid/ready handshake; LOAD accepts a
// stream and writes it into R1..R(NREGS-1). Losing 'halted' kills the operation.
//
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   halted, start, mode  command interface (mode sampled with start: 0=DUMP, 1=LOAD)
//   busy, done, abort    status (busy = state != IDLE, done/abort one-cycle pulses)
//   dbg_ra / dbg_rd      regfile read port (dbg_rd combinational from dbg_ra)
//   dbg_regwrite/wa/wd   regfile write port (registered)
//   out_data/valid/ready dump stream
//   in_data/valid/ready  load stream (in_ready combinational)
module regfile_dbg_port #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned REGBITS = 3
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               halted,
   input  logic               start,
   input  logic               mode,
   output logic               busy,
   output logic               done,
   output logic               abort,
   output logic [REGBITS-1:0] dbg_ra,
   input  logic [WIDTH-1:0]   dbg_rd,
   output logic               dbg_regwrite,
   output logic [REGBITS-1:0] dbg_wa,
   output logic [WIDTH-1:0]   dbg_wd,
   output logic [WIDTH-1:0]   out_data,
   output logic               out_valid,
   input  logic               out_ready,
   input  logic [WIDTH-1:0]   in_data,
   input  logic               in_valid,
   output logic               in_ready
);

   localparam int unsigned NREGS = 1 << REGBITS;
   localparam int unsigned AW    = REGBITS + 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_DUMP  = 2'd1,
      S_DRAIN = 2'd2,
      S_LOAD  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic               rd_vld_q, rd_vld_d;
   logic               busy_d, done_d, abort_d;
   logic [REGBITS-1:0] ra_d, wa_d;
   logic               we_d;
   logic [WIDTH-1:0]   wd_d, odata_d;
   logic               ovalid_d;
   logic [AW-1:0]      addr_inc;

   assign addr_inc = addr_q + AW'(1);

   // Load stream is open only while in LOAD and the core is still halted.
   assign in_ready = (state_q == S_LOAD) && halted;

   // State and registered-output update.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         rd_vld_q     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         abort        <= 1'b0;
         dbg_ra       <= '0;
         dbg_regwrite <= 1'b0;
         dbg_wa       <= '0;
         dbg_wd       <= '0;
         out_data     <= '0;
         out_valid    <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         rd_vld_q     <= rd_vld_d;
         busy         <= busy_d;
         done         <= done_d;
         abort        <= abort_d;
         dbg_ra       <= ra_d;
         dbg_regwrite <= we_d;
         dbg_wa       <= wa_d;
         dbg_wd       <= wd_d;
         out_data     <= odata_d;
         out_valid    <= ovalid_d;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      rd_vld_d = rd_vld_q;
      done_d   = 1'b0;
      abort_d  = 1'b0;
      ra_d     = dbg_ra;
      we_d     = 1'b0;
      wa_d     = dbg_wa;
      wd_d     = dbg_wd;
      odata_d  = out_data;
      ovalid_d = out_valid;

      if ((state_q != S_IDLE) && !halted) begin
         // Losing halted overrides any handshake in the same cycle.
         state_d  = S_IDLE;
         abort_d  = 1'b1;
         ovalid_d = 1'b0;
         rd_vld_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start && halted) begin
                  rd_vld_d = 1'b0;
                  if (!mode) begin
                     state_d = S_DUMP;
                     addr_d  = '0;
                  end else begin
                     state_d = S_LOAD;
                     addr_d  = AW'(1);
                  end
               end
            end
            S_DUMP: begin
               if (!rd_vld_q) begin
                  // First cycle: present the address so dbg_rd is valid next cycle.
                  ra_d     = addr_q[REGBITS-1:0];
                  rd_vld_d = 1'b1;
               end else if (!out_valid || out_ready) begin
                  odata_d  = dbg_rd;
                  ovalid_d = 1'b1;
                  addr_d   = addr_inc;
                  if (addr_q == LAST_ADDR) begin
                     state_d  = S_DRAIN;
                     rd_vld_d = 1'b0;
                  end else begin
                     ra_d = addr_inc[REGBITS-1:0];
                  end
               end
            end
            S_DRAIN: begin
               if (out_ready) begin
                  ovalid_d = 1'b0;
                  done_d   = 1'b1;
                  state_d  = S_IDLE;
               end
            end
            S_LOAD: begin
               if (in_valid) begin
                  we_d   = 1'b1;
                  wa_d   = addr_q[REGBITS-1:0];
                  wd_d   = in_data;
                  addr_d = addr_inc;
                  if (addr_q == LAST_ADDR) begin
                     state_d = S_IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      busy_d = (state_d != S_IDLE);
   end

endmodule

// File: tb/tb_regfile_dbg_port.sv
// Directed bench for regfile_dbg_port with a behavioural 8-entry register file.
module tb_regfile_dbg_port;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       halted, start, mode;
   logic       busy, done, abort;
   logic [2:0] dbg_ra;
   logic [7:0] dbg_rd;
   logic       dbg_regwrite;
   logic [2:0] dbg_wa;
   logic [7:0] dbg_wd;
   logic [7:0] out_data;
   logic       out_valid, out_ready;
   logic [7:0] in_data;
   logic       in_valid, in_ready;

   int n_cmp = 0;
   int n_bad = 0;

   logic [7:0] rf [8];
   logic       rf_init;
   logic [7:0] exp_words [8];

   regfile_dbg_port #(.WIDTH(8), .REGBITS(3)) dut (
      .clk(clk), .reset_n(reset_n), .halted(halted), .start(start), .mode(mode),
      .busy(busy), .done(done), .abort(abort),
      .dbg_ra(dbg_ra), .dbg_rd(dbg_rd), .dbg_regwrite(dbg_regwrite),
      .dbg_wa(dbg_wa), .dbg_wd(dbg_wd),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
   );

   always #5 clk = ~clk;

   // Register file model: combinational read, R0 hardwired to zero.
   assign dbg_rd = (dbg_ra == 3'd0) ? 8'h00 : rf[dbg_ra];

   always @(posedge clk) begin
      if (rf_init) begin
         for (int i = 0; i < 8; i++) rf[i] <= 8'(i * 17);
      end else if (dbg_regwrite && dbg_wa != 3'd0) begin
         rf[dbg_wa] <= dbg_wd;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, 32'(busy), 0);
      chk({tag, "_done"}, 32'(done), 0);
      chk({tag, "_abort"}, 32'(abort), 0);
      chk({tag, "_ra"}, 32'(dbg_ra), 0);
      chk({tag, "_regwrite"}, 32'(dbg_regwrite), 0);
      chk({tag, "_wa"}, 32'(dbg_wa), 0);
      chk({tag, "_wd"}, 32'(dbg_wd), 0);
      chk({tag, "_out_data"}, 32'(out_data), 0);
      chk({tag, "_out_valid"}, 32'(out_valid), 0);
      chk({tag, "_in_ready"}, 32'(in_ready), 0);
   endtask

   // DUMP with either full-rate or 1,0,0 ready pattern; checks order, stability, done.
   task automatic run_dump(input bit toggle);
      int         got;
      int         dcnt;
      bit         fin;
      logic       hs, pv;
      logic [7:0] pd;
      got = 0; dcnt = 0; fin = 0;
      halted = 1'b1; mode = 1'b0; start = 1'b1; out_ready = 1'b1;
      step();
      start = 1'b0;
      for (int c = 0; c < 100 && !fin; c++) begin
         out_ready = toggle ? ((c % 3) == 0) : 1'b1;
         pv = out_valid;
         pd = out_data;
         hs = pv && out_ready;
         step();
         if (hs) begin
            if (got < 8) chk("dump_word", 32'(pd), 32'(exp_words[got]));
            got++;
         end
         if (pv && !out_ready) begin
            chk("dump_hold_valid", 32'(out_valid), 1);
            chk("dump_hold_data", 32'(out_data), 32'(pd));
         end
         if (done) dcnt++;
         if (!busy) fin = 1;
      end
      out_ready = 1'b0;
      chk("dump_finished", 32'(fin), 1);
      chk("dump_count", 32'(got), 8);
      chk("dump_done_pulses", 32'(dcnt), 1);
   endtask

   typedef struct {
      logic       start;
      logic       mode;
      logic [7:0] e_od;
      logic       e_busy;
      logic       e_ov;
      logic       e_done;
   } vec_t;

   vec_t tbl [12];

   initial begin
      int k, pulses;
      bit acc;

      // Full-rate DUMP, with start/mode re-asserted mid-operation (must be ignored).
      tbl[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 1'b1, 8'h11, 1'b1, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 8'h22, 1'b1, 1'b1, 1'b0};
      tbl[5]  = '{1'b0, 1'b0, 8'h33, 1'b1, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 1'b0, 8'h44, 1'b1, 1'b1, 1'b0};
      tbl[7]  = '{1'b0, 1'b0, 8'h55, 1'b1, 1'b1, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 8'h66, 1'b1, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 1'b0, 8'h77, 1'b1, 1'b1, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 1'b0, 8'h77, 1'b0, 1'b0, 1'b0};

      reset_n = 1'b0; halted = 1'b0; start = 1'b0; mode = 1'b0;
      out_ready = 1'b0; in_data = 8'h00; in_valid = 1'b0; rf_init = 1'b1;
      #2;
      chk_all_zero("reset");
      step();
      step();
      rf_init = 1'b0;
      reset_n = 1'b1;
      halted = 1'b1;
      step();

      for (int i = 0; i < 12; i++) begin
         start = tbl[i].start; mode = tbl[i].mode; out_ready = 1'b1;
         step();
         chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
         chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
         chk($sformatf("tbl%0d_data", i), 32'(out_data), 32'(tbl[i].e_od));
         chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].e_done));
         chk($sformatf("tbl%0d_abort", i), 32'(abort), 0);
      end
      start = 1'b0;

      // DUMP under back-pressure.
      for (int i = 0; i < 8; i++) exp_words[i] = 8'(i * 17);
      run_dump(1'b1);

      // LOAD A1..A7 with gaps in in_valid.
      halted = 1'b1; mode = 1'b1; start = 1'b1; in_valid = 1'b0;
      step();
      start = 1'b0;
      chk("load_busy", 32'(busy), 1);
      chk("load_in_ready", 32'(in_ready), 1);
      k = 0; pulses = 0;
      for (int c = 0; c < 60 && k < 7; c++) begin
         in_valid = ((c % 3) != 1);
         in_data = 8'(8'hA1 + k);
         acc = in_valid;
         step();
         if (dbg_regwrite) pulses++;
         if (acc) begin
            k++;
            chk("load_regwrite", 32'(dbg_regwrite), 1);
            chk("load_wa", 32'(dbg_wa), 32'(k));
            chk("load_wd", 32'(dbg_wd), 32'(8'(8'hA0 + k)));
            chk("load_done", 32'(done), 32'(k == 7));
         end else begin
            chk("load_gap_regwrite", 32'(dbg_regwrite), 0);
            chk("load_gap_done", 32'(done), 0);
         end
      end
      in_valid = 1'b0;
      step();
      chk("load_words", 32'(k), 7);
      chk("load_pulses", 32'(pulses), 7);
      chk("load_end_busy", 32'(busy), 0);
      chk("load_end_in_ready", 32'(in_ready), 0);
      chk("load_end_regwrite", 32'(dbg_regwrite), 0);

      exp_words[0] = 8'h00;
      for (int i = 1; i < 8; i++) exp_words[i] = 8'(8'hA0 + i);
      run_dump(1'b1);

      // LOAD aborted after three words; handshake offered in the abort cycle.
      halted = 1'b1; mode = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; in_data = 8'(8'hB1 + i);
         step();
         chk("abl_regwrite", 32'(dbg_regwrite), 1);
      end
      halted = 1'b0; in_valid = 1'b1; in_data = 8'hB4;
      step();
      chk("abort_pulse", 32'(abort), 1);
      chk("abort_done", 32'(done), 0);
      chk("abort_busy", 32'(busy), 0);
      chk("abort_regwrite", 32'(dbg_regwrite), 0);
      in_valid = 1'b0;
      step();
      chk("abort_one_cycle", 32'(abort), 0);
      chk("abort_no_write", 32'(dbg_regwrite), 0);
      for (int i = 1; i < 8; i++)
         chk($sformatf("abort_r%0d", i), 32'(rf[i]),
             32'((i <= 3) ? 8'(8'hB0 + i) : 8'(8'hA0 + i)));
      start = 1'b1; mode = 1'b0;
      step();
      chk("nohalt_start_busy", 32'(busy), 0);
      start = 1'b0;
      step();
      chk("nohalt_start_busy2", 32'(busy), 0);
      chk("nohalt_start_valid", 32'(out_valid), 0);

      // Asynchronous reset in the middle of a DUMP.
      halted = 1'b1; mode = 1'b0; start = 1'b1; out_ready = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("pre_reset_valid", 32'(out_valid), 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk_all_zero("async_reset");
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step();
      exp_words[0] = 8'h00;
      for (int i = 1; i < 8; i++) exp_words[i] = (i <= 3) ? 8'(8'hB0 + i) : 8'(8'hA0 + i);
      run_dump(1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
